sobel_window_filter: RTL and testbench

Downstream stage of the image-processing datapath. Consumes one 3x3 pixel window per handshake from the BRAM line-buffer/window extractor and produces one 8-bit Sobel gradient-magnitude pixel per window. The block is a 3-stage pipeline with valid/ready flow control on both sides. A frame counter marks the last output pixel and pulses a completion flag.

---
 rtl/image_proc_pkg.sv | 26 ++
 rtl/sobel_grad.sv | 23 ++
 rtl/sobel_window_filter.sv | 143 ++++++++++++++
 tb/tb_sobel_window_filter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_proc_pkg.sv
// Shared types and constants for the image-processing datapath:
// pixel width, Sobel kernel weights, gradient width and the 3x3 window struct.
package image_proc_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;

  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

  // Sobel kernel weights: outer rows/columns weigh 1, the centre row/column weighs 2.
  localparam logic signed [GRAD_W-1:0] SOBEL_K_EDGE = 11'sd1;
  localparam logic signed [GRAD_W-1:0] SOBEL_K_MID  = 11'sd2;

  typedef struct packed {
    logic [PIX_W-1:0] p1;
    logic [PIX_W-1:0] p2;
    logic [PIX_W-1:0] p3;
    logic [PIX_W-1:0] p4;
    logic [PIX_W-1:0] p5;
    logic [PIX_W-1:0] p6;
    logic [PIX_W-1:0] p7;
    logic [PIX_W-1:0] p8;
    logic [PIX_W-1:0] p9;
  } sobel_win_t;

endpackage

// File: rtl/sobel_grad.sv
// Stage-1 Sobel gradient: combinational Gx/Gy from one 3x3 window.
// The parent registers the results.
module sobel_grad
  import image_proc_pkg::*;
(
  input  sobel_win_t               win_i,
  output logic signed [GRAD_W-1:0] gx_o,
  output logic signed [GRAD_W-1:0] gy_o
);

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  // 11 signed bits cover the full +/-1020 range, so no intermediate overflow.
  always_comb begin
    gx_o = (SOBEL_K_EDGE * ext(win_i.p3) + SOBEL_K_MID * ext(win_i.p6) + SOBEL_K_EDGE * ext(win_i.p9))
         - (SOBEL_K_EDGE * ext(win_i.p1) + SOBEL_K_MID * ext(win_i.p4) + SOBEL_K_EDGE * ext(win_i.p7));
    gy_o = (SOBEL_K_EDGE * ext(win_i.p7) + SOBEL_K_MID * ext(win_i.p8) + SOBEL_K_EDGE * ext(win_i.p9))
         - (SOBEL_K_EDGE * ext(win_i.p1) + SOBEL_K_MID * ext(win_i.p2) + SOBEL_K_EDGE * ext(win_i.p3));
  end

endmodule

// File: rtl/sobel_window_filter.sv
// 3-stage Sobel magnitude pipeline with valid/ready flow control and a frame counter.
// Optional macro SOBEL_THRESH_EN adds a thresh port and binarises the output.
module sobel_window_filter
  import image_proc_pkg::*;
#(
  parameter int FRAME_PIXELS = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] win_p1,
  input  logic [PIX_W-1:0] win_p2,
  input  logic [PIX_W-1:0] win_p3,
  input  logic [PIX_W-1:0] win_p4,
  input  logic [PIX_W-1:0] win_p5,
  input  logic [PIX_W-1:0] win_p6,
  input  logic [PIX_W-1:0] win_p7,
  input  logic [PIX_W-1:0] win_p8,
  input  logic [PIX_W-1:0] win_p9,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy
`ifdef SOBEL_THRESH_EN
  , input  logic [PIX_W-1:0] thresh
`endif
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready; the whole
  // pipeline moves only when stage 3 is empty or being drained (adv).
  sobel_win_t                win;
  logic signed [GRAD_W-1:0]  gx_c, gy_c;
  logic                      adv, in_hs, out_hs, is_last;

  logic                      s1_valid_q, s1_valid_d;
  logic signed [GRAD_W-1:0]  gx_q, gx_d, gy_q, gy_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [GRAD_W-1:0]         mag_q, mag_d;
  logic                      s3_valid_q, s3_valid_d;
  logic [PIX_W-1:0]          pix_q, pix_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;

  function automatic logic [GRAD_W-1:0] abs_g(input logic signed [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] r;
    r = g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
    return r;
  endfunction

  assign win = '{p1: win_p1, p2: win_p2, p3: win_p3, p4: win_p4, p5: win_p5,
                 p6: win_p6, p7: win_p7, p8: win_p8, p9: win_p9};

  sobel_grad u_grad (
    .win_i (win),
    .gx_o  (gx_c),
    .gy_o  (gy_c)
  );

  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = adv && !start && !reset;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = s3_valid_q && out_ready;
  assign is_last  = (count_q == CNT_W'(FRAME_PIXELS - 1));

  always_comb begin
    s1_valid_d = s1_valid_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    s2_valid_d = s2_valid_q;
    mag_d      = mag_q;
    s3_valid_d = s3_valid_q;
    pix_d      = pix_q;
    count_d    = count_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    // start flushes everything and wins over a same-cycle output handshake.
    if (start) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s3_valid_d = 1'b0;
      count_d    = '0;
      busy_d     = 1'b0;
    end else begin
      if (adv) begin
        s1_valid_d = in_hs;
        gx_d       = gx_c;
        gy_d       = gy_c;
        s2_valid_d = s1_valid_q;
        mag_d      = abs_g(gx_q) + abs_g(gy_q);
        s3_valid_d = s2_valid_q;
`ifdef SOBEL_THRESH_EN
        pix_d      = (mag_q >= GRAD_W'(thresh)) ? PIX_MAX : '0;
`else
        pix_d      = (mag_q > GRAD_W'(PIX_MAX)) ? PIX_MAX : mag_q[PIX_W-1:0];
`endif
      end
      if (out_hs) count_d = is_last ? '0 : count_q + CNT_W'(1);
      done_d = out_hs && is_last;
      if (in_hs) busy_d = 1'b1;
      else if (out_hs && is_last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      s2_valid_q <= 1'b0;
      mag_q      <= '0;
      s3_valid_q <= 1'b0;
      pix_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      s2_valid_q <= s2_valid_d;
      mag_q      <= mag_d;
      s3_valid_q <= s3_valid_d;
      pix_q      <= pix_d;
      count_q    <= count_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign pix_out    = pix_q;
  assign out_valid  = s3_valid_q;
  assign out_last   = s3_valid_q && is_last;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sobel_window_filter.sv
// Directed bench for sobel_window_filter with FRAME_PIXELS = 4; inputs change 1ns after
// the rising edge and outputs/handshakes are sampled on the falling edge.
`timescale 1ns/1ps
module tb_sobel_window_filter;
  import image_proc_pkg::*;

  localparam int FP = 4;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_ready, out_valid, out_ready;
  logic       out_last, frame_done, busy;
  logic [7:0] pix_out;
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh;
`endif
  sobel_win_t win;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  sobel_window_filter #(.FRAME_PIXELS(FP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .win_p1     (win.p1),
    .win_p2     (win.p2),
    .win_p3     (win.p3),
    .win_p4     (win.p4),
    .win_p5     (win.p5),
    .win_p6     (win.p6),
    .win_p7     (win.p7),
    .win_p8     (win.p8),
    .win_p9     (win.p9),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pix_out    (pix_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef SOBEL_THRESH_EN
    , .thresh   (thresh)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic sobel_win_t grad_win(input int k);
    sobel_win_t w;
    w    = '0;
    w.p3 = 8'(k);
    w.p6 = 8'(k);
    w.p9 = 8'(k);
    return w;
  endfunction

  task automatic send_win(input sobel_win_t w);
    bit hs;
    hs       = 1'b0;
    win      = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (!hs) begin miscompares++; $display("FAIL send_timeout: in_ready never seen, got 0 want 1"); end
  endtask

  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; win = '0;
`ifdef SOBEL_THRESH_EN
    thresh = 8'd0;
`endif
    repeat (3) tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (pix_out !== 8'h00) begin miscompares++; $display("FAIL reset_pix_out: got %h want 00", pix_out); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_flat();
    pulse_start();
    win      = '{default: 8'd100};
    in_valid = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flat_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flat_early_valid cycle %0d: got %b want 0", c, out_valid); end
      tick();
    end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flat_latency: out_valid got %b want 1", out_valid); end
    vectors++; if (pix_out !== 8'd0) begin miscompares++; $display("FAIL flat_pix: got %0d want 0", pix_out); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL flat_last: got %b want 0", out_last); end
    tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flat_dup: out_valid got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_vertical();
    sobel_win_t w;
    bit seen;
    pulse_start();
    w = '{p1: 8'd0, p2: 8'd128, p3: 8'd255, p4: 8'd0, p5: 8'd128, p6: 8'd255,
          p7: 8'd0, p8: 8'd128, p9: 8'd255};
    send_win(w);
    wait_out(seen);
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL vert_timeout: out_valid got 0 want 1"); end
`ifdef SOBEL_THRESH_EN
    vectors++; if (pix_out !== 8'hFF) begin miscompares++; $display("FAIL vert_pix: got %h want ff", pix_out); end
`else
    vectors++; if (pix_out !== 8'd255) begin miscompares++; $display("FAIL vert_pix: got %0d want 255", pix_out); end
`endif
    tick();
  endtask

  task automatic test_gradient();
    sobel_win_t w;
    bit seen;
    logic [7:0] want;
    pulse_start();
`ifdef SOBEL_THRESH_EN
    for (int t = 0; t < 2; t++) begin
      thresh = (t == 0) ? 8'd50 : 8'd40;
      want   = (t == 0) ? 8'h00 : 8'hFF;
      send_win(grad_win(10));
      wait_out(seen);
      vectors++; if (seen !== 1'b1 || pix_out !== want) begin miscompares++; $display("FAIL grad_thresh_%0d: got %h want %h", thresh, pix_out, want); end
      tick();
    end
    thresh = 8'd50;
    want   = 8'hFF;
`else
    send_win(grad_win(10));
    wait_out(seen);
    vectors++; if (seen !== 1'b1 || pix_out !== 8'd40) begin miscompares++; $display("FAIL grad_pix: got %0d want 40", pix_out); end
    tick();
    want = 8'd80;
`endif
    // Negative Gy: top row 20, rest 0 -> Gx = 0, Gy = -80, magnitude 80.
    w = '0; w.p1 = 8'd20; w.p2 = 8'd20; w.p3 = 8'd20;
    send_win(w);
    wait_out(seen);
    vectors++; if (seen !== 1'b1 || pix_out !== want) begin miscompares++; $display("FAIL grad_neg_gy: got %h want %h", pix_out, want); end
    tick();
  endtask

  task automatic test_backpressure();
    int got;
    logic [7:0] e;
    pulse_start();
    out_ready = 1'b1;
    exp_q.delete();
    for (int k = 1; k <= 8; k++) exp_q.push_back(8'(4 * k));
    got = 0;
    fork
      begin
        for (int k = 1; k <= 8; k++) send_win(grad_win(k));
      end
      begin
        repeat (6) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 80 && got < 8; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            got++;
            vectors++; if (pix_out !== e) begin miscompares++; $display("FAIL bp_order #%0d: got %0d want %0d", got, pix_out, e); end
          end else if (out_valid && !out_ready) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_stall: got %b want 0", in_ready); end
            vectors++; if (exp_q.size() == 0 || pix_out !== exp_q[0]) begin miscompares++; $display("FAIL bp_hold: got %0d want %0d", pix_out, (exp_q.size() > 0) ? exp_q[0] : 8'hxx); end
          end
        end
      end
    join
    vectors++; if (got !== 8) begin miscompares++; $display("FAIL bp_count: got %0d outputs want 8", got); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_extra: out_valid got %b want 0", out_valid); end
    end
    tick();
  endtask

  task automatic test_frame();
    int  n;
    bit  done_exp, busy_low_chk;
    pulse_start();
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL frame_busy_idle: got %b want 0", busy); end
    tick();
    n = 0; done_exp = 1'b0; busy_low_chk = 1'b0;
    fork
      begin
        for (int k = 1; k <= FP; k++) send_win(grad_win(k));
      end
      begin
        for (int c = 0; c < 15; c++) begin
          @(negedge clk);
          vectors++; if (frame_done !== done_exp) begin miscompares++; $display("FAIL frame_done cycle %0d: got %b want %b", c, frame_done, done_exp); end
          if (busy_low_chk) begin
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL frame_busy_fall: got %b want 0", busy); end
          end
          done_exp = 1'b0;
          busy_low_chk = 1'b0;
          if (out_valid && out_ready) begin
            n++;
            vectors++; if (out_last !== (n == FP)) begin miscompares++; $display("FAIL frame_last #%0d: got %b want %b", n, out_last, (n == FP)); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL frame_busy_high #%0d: got %b want 1", n, busy); end
            if (n == FP) begin done_exp = 1'b1; busy_low_chk = 1'b1; end
          end
        end
      end
    join
    vectors++; if (n !== FP) begin miscompares++; $display("FAIL frame_count: got %0d want %0d", n, FP); end
  endtask

  task automatic test_start_flush();
    bit seen;
    int n;
    pulse_start();
    out_ready = 1'b1;
    send_win(grad_win(1));
    send_win(grad_win(2));
    start = 1'b1; win = grad_win(3); in_valid = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL start_in_ready: got %b want 0", in_ready); end
    tick();
    start = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL start_flush_valid cycle %0d: got %b want 0", c, out_valid); end
      if (c == 0) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_busy: got %b want 0", busy); end
      end
      tick();
    end
    // Bring the count to FP-1, then hit start on the last pixel's handshake cycle.
    for (int k = 1; k < FP; k++) send_win(grad_win(k));
    repeat (5) tick();
    out_ready = 1'b0;
    send_win(grad_win(FP));
    wait_out(seen);
    vectors++; if (seen !== 1'b1 || out_last !== 1'b1) begin miscompares++; $display("FAIL start_pre_last: out_last got %b want 1", out_last); end
    tick();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL start_no_done cycle %0d: got %b want 0", c, frame_done); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL start_drop cycle %0d: got %b want 0", c, out_valid); end
      tick();
    end
    n = 0;
    fork
      begin
        for (int k = 5; k < 5 + FP; k++) send_win(grad_win(k));
      end
      begin
        for (int c = 0; c < 15; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            n++;
            vectors++; if (out_last !== (n == FP)) begin miscompares++; $display("FAIL start_next_last #%0d: got %b want %b", n, out_last, (n == FP)); end
            vectors++; if (pix_out !== 8'(4 * (n + 4))) begin miscompares++; $display("FAIL start_next_pix #%0d: got %0d want %0d", n, pix_out, 4 * (n + 4)); end
          end
        end
      end
    join
    vectors++; if (n !== FP) begin miscompares++; $display("FAIL start_next_count: got %0d want %0d", n, FP); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    pulse_start();
    out_ready = 1'b0;
    send_win(grad_win(1));
    send_win(grad_win(2));
    wait_out(seen);
    vectors++; if (seen !== 1'b1 || pix_out !== 8'd4) begin miscompares++; $display("FAIL rst_mid_pre: pix got %0d want 4", pix_out); end
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    vectors++; if (pix_out !== 8'h00) begin miscompares++; $display("FAIL rst_mid_pix: got %h want 00", pix_out); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_mid_last: got %b want 0", out_last); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done: got %b want 0", frame_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    tick();
    reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_discard cycle %0d: got %b want 0", c, out_valid); end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_flat();
    test_vertical();
    test_gradient();
    test_backpressure();
    test_frame();
    test_start_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
